// File: rtl/pipe_ctrl.sv
// Pipeline hazard/redirect controller: branch flush, load-use stall, memory wait with sticky timeout.
// Optional PIPE_CTRL_PERF_EN adds stall_cycles / flush_count performance counters.
module pipe_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_is_load,
  input  logic        mem_busy,
  output logic [31:0] next_pc,
  output logic        pc_pause,
  output logic        if_id_pause,
  output logic        if_id_flush,
  output logic        id_ex_pause,
  output logic        id_ex_flush,
  output logic        ex_mem_pause,
  output logic        mem_timeout,
`ifdef PIPE_CTRL_PERF_EN
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count,
`endif
  output logic [1:0]  state
);

  // state    | meaning
  // RUN      | normal issue, all events evaluated
  // LU_STALL | one-cycle load-use bubble, hazard check suppressed
  // FLUSH    | one-cycle redirect shadow, EX holds a bubble
  // MEM_WAIT | data memory busy, whole pipe frozen
  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] LU_STALL = 2'd1;
  localparam logic [1:0] FLUSH    = 2'd2;
  localparam logic [1:0] MEM_WAIT = 2'd3;

  localparam int             CW       = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0]  WAIT_MAX = CW'(MEM_TIMEOUT);

  logic [1:0]    state_nxt;
  logic [CW-1:0] wait_cnt;
  logic [CW-1:0] wait_nxt;
  logic          load_use;
  logic          redirect;

  assign load_use = ex_is_load && (ex_rd != 5'd0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));

  always_comb begin
    next_pc      = pc + 32'd4;
    pc_pause     = 1'b0;
    if_id_pause  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_pause  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_pause = 1'b0;
    redirect     = 1'b0;
    state_nxt    = RUN;
    if (rst) begin
      next_pc     = RESET_PC;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (mem_busy) begin
      next_pc      = pc;
      pc_pause     = 1'b1;
      if_id_pause  = 1'b1;
      id_ex_pause  = 1'b1;
      ex_mem_pause = 1'b1;
      state_nxt    = MEM_WAIT;
    end else if (branch_taken && (state != FLUSH)) begin
      // a branch frozen in EX during MEM_WAIT is honoured here on exit
      next_pc     = branch_target;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      redirect    = 1'b1;
      state_nxt   = FLUSH;
    end else if (load_use && ((state == RUN) || (state == MEM_WAIT))) begin
      next_pc     = pc;
      pc_pause    = 1'b1;
      if_id_pause = 1'b1;
      id_ex_flush = 1'b1;
      state_nxt   = LU_STALL;
    end
  end

  // The cycle that enters MEM_WAIT counts too, so MEM_TIMEOUT consecutive busy cycles trip the flag.
  always_comb begin
    wait_nxt = '0;
    if (mem_busy)
      wait_nxt = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (mem_busy && (wait_nxt == WAIT_MAX))
        mem_timeout <= 1'b1;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (pc_pause)
        stall_cycles <= stall_cycles + 32'd1;
      if (redirect)
        flush_count <= flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl; perf counter checks build only with PIPE_CTRL_PERF_EN.
module tb_pipe_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_use_rs1, id_use_rs2, ex_is_load, mem_busy;
  logic [31:0] next_pc;
  logic        pc_pause, if_id_pause, if_id_flush, id_ex_pause, id_ex_flush, ex_mem_pause;
  logic        mem_timeout;
  logic [1:0]  state;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles, flush_count;
`endif
  logic [5:0]  ctl;

  int checks = 0;
  int fails  = 0;

  localparam logic [5:0] C_NONE = 6'b000000;
  localparam logic [5:0] C_FL   = 6'b001010;
  localparam logic [5:0] C_LU   = 6'b110010;
  localparam logic [5:0] C_MW   = 6'b110101;

  pipe_ctrl #(.RESET_PC(32'h0000_1000), .MEM_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .pc(pc),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .mem_busy(mem_busy),
    .next_pc(next_pc), .pc_pause(pc_pause),
    .if_id_pause(if_id_pause), .if_id_flush(if_id_flush),
    .id_ex_pause(id_ex_pause), .id_ex_flush(id_ex_flush),
    .ex_mem_pause(ex_mem_pause), .mem_timeout(mem_timeout),
`ifdef PIPE_CTRL_PERF_EN
    .stall_cycles(stall_cycles), .flush_count(flush_count),
`endif
    .state(state)
  );

  assign ctl = {pc_pause, if_id_pause, if_id_flush, id_ex_pause, id_ex_flush, ex_mem_pause};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; pc = 32'h100; branch_taken = 1'b0; branch_target = 32'h0;
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_is_load = 1'b0; mem_busy = 1'b0;
    #2;
    chk("rst_next_pc", next_pc, 32'h1000);
    chk("rst_ctl", ctl, C_FL);
    chk("rst_state", state, 0);
    chk("rst_timeout", mem_timeout, 0);
    tick(); tick();
    rst = 1'b0; #1;
    chk("run_next_pc", next_pc, 32'h104);
    chk("run_ctl", ctl, C_NONE);
    chk("run_state", state, 0);
`ifdef PIPE_CTRL_PERF_EN
    chk("rst_stall_cycles", stall_cycles, 0);
    chk("rst_flush_count", flush_count, 0);
`endif

    // load-use through rs1
    ex_is_load = 1'b1; ex_rd = 5'd5; id_use_rs1 = 1'b1; id_rs1 = 5'd5; #1;
    chk("lu1_ctl", ctl, C_LU);
    chk("lu1_next_pc", next_pc, 32'h100);
    tick();
    chk("lu1_state", state, 1);
    chk("lu1_suppressed_ctl", ctl, C_NONE);
    chk("lu1_stall_next_pc", next_pc, 32'h104);
    tick();
    ex_is_load = 1'b0; id_use_rs1 = 1'b0; #1;
    chk("lu1_back_run", state, 0);
    chk("lu1_back_ctl", ctl, C_NONE);

    // ex_rd = x0 never stalls
    ex_is_load = 1'b1; ex_rd = 5'd0; id_use_rs1 = 1'b1; id_rs1 = 5'd0; #1;
    chk("x0_ctl", ctl, C_NONE);
    tick();
    chk("x0_state", state, 0);

    // load-use through rs2, branch arriving during LU_STALL is honoured
    id_use_rs1 = 1'b0; ex_rd = 5'd7; id_use_rs2 = 1'b1; id_rs2 = 5'd7; #1;
    chk("lu2_ctl", ctl, C_LU);
    tick();
    ex_is_load = 1'b0; id_use_rs2 = 1'b0;
    branch_taken = 1'b1; branch_target = 32'h200; #1;
    chk("lu2_state", state, 1);
    chk("lu2_br_next_pc", next_pc, 32'h200);
    chk("lu2_br_ctl", ctl, C_FL);
    tick();
    chk("flush_state", state, 2);
    chk("flush_ignore_br_pc", next_pc, 32'h104);
    chk("flush_ignore_br_ctl", ctl, C_NONE);
    tick();
    branch_taken = 1'b0; #1;
    chk("flush_back_run", state, 0);
`ifdef PIPE_CTRL_PERF_EN
    chk("perf_stall_cycles", stall_cycles, 2);
    chk("perf_flush_count", flush_count, 1);
`endif

    // mem_busy 3 cycles with a pending branch
    mem_busy = 1'b1; branch_taken = 1'b1; branch_target = 32'h300; #1;
    chk("mw_ctl", ctl, C_MW);
    chk("mw_next_pc", next_pc, 32'h100);
    tick();
    chk("mw_state", state, 3);
    chk("mw_ctl2", ctl, C_MW);
    tick(); tick();
    mem_busy = 1'b0; #1;
    chk("mw_exit_state", state, 3);
    chk("mw_exit_next_pc", next_pc, 32'h300);
    chk("mw_exit_ctl", ctl, C_FL);
    tick();
    branch_taken = 1'b0; #1;
    chk("mw_exit_flush", state, 2);
    tick();
    chk("mw_run_again", state, 0);
    chk("mw_no_timeout", mem_timeout, 0);

    // timeout boundary: 15 busy cycles do not trip, 16 do
    mem_busy = 1'b1;
    repeat (15) tick();
    chk("to_15", mem_timeout, 0);
    mem_busy = 1'b0;
    tick();
    mem_busy = 1'b1;
    repeat (15) tick();
    chk("to_15b", mem_timeout, 0);
    tick();
    chk("to_16", mem_timeout, 1);
    mem_busy = 1'b0;
    tick(); tick();
    chk("to_sticky", mem_timeout, 1);
    chk("to_state", state, 0);

    // simultaneous mem_busy, branch and load-use: memory wins
    mem_busy = 1'b1; branch_taken = 1'b1; branch_target = 32'h400;
    ex_is_load = 1'b1; ex_rd = 5'd3; id_use_rs1 = 1'b1; id_rs1 = 5'd3; #1;
    chk("prio_ctl", ctl, C_MW);
    chk("prio_next_pc", next_pc, 32'h100);
    tick();
    chk("prio_state", state, 3);
    mem_busy = 1'b0; branch_taken = 1'b0; ex_is_load = 1'b0; id_use_rs1 = 1'b0; #1;
    chk("mw_exit_default_pc", next_pc, 32'h104);
    chk("mw_exit_default_ctl", ctl, C_NONE);
    tick();

    pc = 32'hFFFF_FFFC; #1;
    chk("wrap_next_pc", next_pc, 32'h0);
    pc = 32'h100;

    // reset mid-MEM_WAIT
    mem_busy = 1'b1;
    tick(); tick();
    chk("pre_rst_state", state, 3);
    #2 rst = 1'b1; #1;
    chk("rst_mw_state", state, 0);
    chk("rst_mw_timeout", mem_timeout, 0);
    chk("rst_mw_next_pc", next_pc, 32'h1000);
    chk("rst_mw_ctl", ctl, C_FL);
`ifdef PIPE_CTRL_PERF_EN
    chk("rst_mw_stall_cycles", stall_cycles, 0);
    chk("rst_mw_flush_count", flush_count, 0);
`endif
    mem_busy = 1'b0;
    tick();
    rst = 1'b0; #1;
    chk("post_rst_state", state, 0);
    chk("post_rst_next_pc", next_pc, 32'h104);
    chk("post_rst_ctl", ctl, C_NONE);

    // reset mid-FLUSH
    branch_taken = 1'b1; branch_target = 32'h200;
    tick();
    branch_taken = 1'b0; #1;
    chk("pre_rst_flush", state, 2);
    rst = 1'b1; #1;
    chk("rst_flush_state", state, 0);
    tick();
    rst = 1'b0; #1;
    chk("post_rst2_state", state, 0);
    chk("post_rst2_ctl", ctl, C_NONE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning next_pc driven during reset.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 16, meaning consecutive mem_busy cycles before timeout flag.
REQ-003 clk  in  1  clock, rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 pc  in  32  current PC from pc register.
REQ-006 branch_taken  in  1  EX-stage taken branch/jump; branch_target  in  32  its target.
REQ-007 id_rs1, id_rs2  in  5 each  ID source regs; id_use_rs1, id_use_rs2  in  1 each  source valid.
REQ-008 ex_rd  in  5  EX destination; ex_is_load  in  1  EX holds a load.
REQ-009 mem_busy  in  1  data memory not ready this cycle.
REQ-010 next_pc  out  32  to pc register; pc_pause  out  1  to pc register.
REQ-011 if_id_pause, if_id_flush, id_ex_pause, id_ex_flush, ex_mem_pause  out  1 each  stage-register controls.
REQ-012 mem_timeout  out  1  sticky timeout flag; state  out  2  current FSM state.

Function
REQ-013 SHALL implement FSM: RUN=2'd0, LU_STALL=2'd1, FLUSH=2'd2, MEM_WAIT=2'd3; outputs combinational from state and inputs; state updates on rising clk.
REQ-014 Event priority each cycle: mem_busy > branch_taken > load-use hazard > none.
REQ-015 Load-use hazard = ex_is_load & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
REQ-016 Default (no event): next_pc=pc+4 (mod 2^32, wraps 32'hFFFF_FFFC->0), all pause/flush outputs 0, state stays/returns RUN.
REQ-017 mem_busy=1 in any state: pc_pause, if_id_pause, id_ex_pause, ex_mem_pause=1, flushes=0, next_pc=pc, next state MEM_WAIT.
REQ-018 MEM_WAIT with mem_busy=0: evaluate branch/hazard as in RUN same cycle; pending branch_taken held by frozen EX is therefore honoured on exit.
REQ-019 branch_taken (no mem_busy, state!=FLUSH): next_pc=branch_target, if_id_flush=1, id_ex_flush=1, pauses 0, next state FLUSH.
REQ-020 FLUSH lasts exactly one cycle; branch_taken and hazard ignored in it (EX holds bubble); behaves as default otherwise; next state RUN unless mem_busy.
REQ-021 Load-use (no mem_busy, no branch, state RUN): pc_pause=1, if_id_pause=1, id_ex_flush=1, next_pc=pc, next state LU_STALL.
REQ-022 LU_STALL lasts exactly one cycle, hazard detection suppressed, branch_taken honoured; then RUN.
REQ-023 Flush and pause SHALL never both be 1 for the same stage register.
REQ-024 Wait counter: increments each MEM_WAIT cycle with mem_busy=1, saturating; clears when mem_busy=0; mem_timeout set when counter reaches MEM_TIMEOUT, stays 1 until reset.
REQ-025 Branch target alignment not checked; target passed through unmodified.

Reset
REQ-026 rst asserted (asynchronously): state=RUN, wait counter=0, mem_timeout=0, perf counters=0.
REQ-027 While rst=1: next_pc=RESET_PC, all pauses=0, if_id_flush=id_ex_flush=1.
REQ-028 Reset mid-MEM_WAIT or mid-FLUSH SHALL abandon the operation; first cycle after deassertion is RUN with default behaviour.

Configuration
REQ-029 Macro PIPE_CTRL_PERF_EN defined: add outputs stall_cycles (32) counting cycles with pc_pause=1, and flush_count (32) counting branch redirects (REQ-019); both wrap at 2^32.
REQ-030 Macro undefined: those ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-031 Reset release, no events, pc=0x100 -> next_pc=0x104, all controls 0, state=RUN.
REQ-032 ex_is_load=1, ex_rd=5, id_use_rs1=1, id_rs1=5 -> one cycle pc_pause=1, if_id_pause=1, id_ex_flush=1, state LU_STALL then RUN; ex_rd=0 -> no stall.
REQ-033 branch_taken=1, target=0x200 -> next_pc=0x200, both flushes=1, next cycle FLUSH with branch_taken=1 ignored, then RUN.
REQ-034 mem_busy held 3 cycles with branch_taken=1 -> all pauses 1 for 3 cycles, then next_pc=target and flushes; mem_busy held 16 cycles -> mem_timeout=1 sticky.
REQ-035 mem_busy and branch_taken and load-use same cycle -> MEM_WAIT response only; pc=0xFFFF_FFFC default -> next_pc=0.
REQ-036 With PIPE_CTRL_PERF_EN: 2 load-use stalls + 1 branch -> stall_cycles=2, flush_count=1; rst mid-MEM_WAIT -> counters 0, state RUN.
